// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package microwave_pkg;

  // Width of one BCD digit
  localparam int DIGIT_W = 4;

  // Largest legal value of a ones digit and of a tens-of-seconds digit
  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/microwave_timer_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Latency: tick is combinational from the count register; first tick TICK_DIV enabled cycles after restart.
// Backpressure: none; i_en low freezes the count, i_restart clears it (restart wins over enable).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_en        count enable; the count holds while low
//   i_restart   synchronous clear of the count to 0
//   o_tick      high for the enabled cycle in which the count equals TICK_DIV-1
//
// TICK_DIV must be at least 2.
module tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/microwave_timer.sv
// Microwave time-keeping core: keypad M:SS entry, 1 s BCD countdown, door/start/stop state machine.
// Latency: every output is registered; an input strobe is reflected one cycle after it is sampled.
// Backpressure: none; strobes are acted on in the cycle they appear, lower-priority events are dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_valid, key_digit  keypad strobe and BCD digit (accepted in IDLE only)
//   start, stop, clear    one-cycle control strobes
//   door_closed           door level, 1 = shut
//   min, sec_tens, sec_ones  displayed time, BCD
//   mag_on                magnetron enable, high only in RUN
//   done                  high while in DONE
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_closed,
  output logic [DIGIT_W-1:0] min,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               mag_on,
  output logic               done
);

  state_t r_state, w_state_nxt;

  logic [DIGIT_W-1:0] r_min, r_tens, r_ones;
  logic [DIGIT_W-1:0] w_min_nxt, w_tens_nxt, w_ones_nxt;
  logic [DIGIT_W-1:0] w_dec_min, w_dec_tens, w_dec_ones;
  logic               r_mag_on, r_done;
  logic               w_tick, w_time_zero, w_dec_zero, w_door_open;
  logic               w_run_ok, w_tick_en, w_restart, w_key_ok;

  assign w_door_open = ~door_closed;
  assign w_time_zero = (r_min == '0) && (r_tens == '0) && (r_ones == '0);

  // No clear, stop or door-open this cycle: the lower-priority actions may proceed
  assign w_run_ok = ~clear & ~stop & door_closed;

  // Prescaler freezes on the cycle RUN is left, so a pause resumes mid-second
  assign w_tick_en = (r_state == RUN) && w_run_ok;
  assign w_restart = (r_state == IDLE) && w_run_ok && start && !w_time_zero;

  // Rejecting a key while sec_ones > 5 keeps the shifted sec_tens within 0-5
  assign w_key_ok = (key_digit <= BCD_MAX_ONES) && (r_ones <= BCD_MAX_TENS);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_tick_en),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // BCD decrement with borrow from ones into tens into minutes
  always_comb begin
    w_dec_min  = r_min;
    w_dec_tens = r_tens;
    w_dec_ones = r_ones;
    if (r_ones != '0) begin
      w_dec_ones = r_ones - 1'b1;
    end else begin
      w_dec_ones = BCD_MAX_ONES;
      if (r_tens != '0) begin
        w_dec_tens = r_tens - 1'b1;
      end else begin
        w_dec_tens = BCD_MAX_TENS;
        w_dec_min  = r_min - 1'b1;
      end
    end
  end

  assign w_dec_zero = (w_dec_min == '0) && (w_dec_tens == '0) && (w_dec_ones == '0);

  // Next state and digits; each if-chain follows clear > stop > door open > start > key
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_min_nxt  = '0;
          w_tens_nxt = '0;
          w_ones_nxt = '0;
        end else if (stop || w_door_open) begin
          // nothing to stop; an open door blocks start and key entry
        end else if (start) begin
          if (!w_time_zero) w_state_nxt = RUN;
        end else if (key_valid && w_key_ok) begin
          w_min_nxt  = r_tens;
          w_tens_nxt = r_ones;
          w_ones_nxt = key_digit;
        end
      end
      RUN: begin
        if (clear) begin
          w_state_nxt = IDLE;
          w_min_nxt   = '0;
          w_tens_nxt  = '0;
          w_ones_nxt  = '0;
        end else if (stop || w_door_open) begin
          w_state_nxt = PAUSE;
        end else if (w_tick) begin
          w_min_nxt  = w_dec_min;
          w_tens_nxt = w_dec_tens;
          w_ones_nxt = w_dec_ones;
          if (w_dec_zero) w_state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (clear || stop) begin
          w_state_nxt = IDLE;
          w_min_nxt   = '0;
          w_tens_nxt  = '0;
          w_ones_nxt  = '0;
        end else if (w_door_open) begin
          // door movement alone does not resume or cancel
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        w_min_nxt  = '0;
        w_tens_nxt = '0;
        w_ones_nxt = '0;
        if (clear || stop || w_door_open) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_min_nxt   = '0;
        w_tens_nxt  = '0;
        w_ones_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_min    <= '0;
      r_tens   <= '0;
      r_ones   <= '0;
      r_mag_on <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_min    <= w_min_nxt;
      r_tens   <= w_tens_nxt;
      r_ones   <= w_ones_nxt;
      r_mag_on <= (w_state_nxt == RUN);
      r_done   <= (w_state_nxt == DONE);
    end
  end

  assign min      = r_min;
  assign sec_tens = r_tens;
  assign sec_ones = r_ones;
  assign mag_on   = r_mag_on;
  assign done     = r_done;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV = 4.
// Latency: outputs sampled on the falling edge following each applied input cycle.
// Backpressure: n/a.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min_o, tens_o, ones_o;
  logic       mag_on_o, done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  microwave_timer #(
    .TICK_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .min         (min_o),
    .sec_tens    (tens_o),
    .sec_ones    (ones_o),
    .mag_on      (mag_on_o),
    .done        (done_o)
  );

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       st, sp, cl, dc;
    logic [3:0] m, t, o;
    logic       mg, dn;
  } vec_t;

  function automatic vec_t v(input logic kv, input logic [3:0] kd,
                             input logic st, input logic sp, input logic cl, input logic dc,
                             input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                             input logic mg, input logic dn);
    vec_t r;
    r.kv = kv; r.kd = kd; r.st = st; r.sp = sp; r.cl = cl; r.dc = dc;
    r.m = m; r.t = t; r.o = o; r.mg = mg; r.dn = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] m, input logic [3:0] t,
                     input logic [3:0] o, input logic mg, input logic dn);
    n_checks++;
    if ({min_o, tens_o, ones_o, mag_on_o, done_o} !== {m, t, o, mg, dn}) begin
      n_errors++;
      $display("FAIL %s: got %0d:%0d%0d mag_on=%b done=%b, expected %0d:%0d%0d mag_on=%b done=%b",
               nm, min_o, tens_o, ones_o, mag_on_o, done_o, m, t, o, mg, dn);
    end
  endtask

  // Drive one cycle of inputs from a falling edge; return on the next falling edge
  task automatic apply(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sp, input logic cl, input logic dc);
    key_valid   = kv;
    key_digit   = kd;
    start       = st;
    stop        = sp;
    clear       = cl;
    door_closed = dc;
    @(negedge clk);
    key_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic nops(input int n);
    repeat (n) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic key(input logic [3:0] d);
    apply(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  localparam int NV = 24;
  vec_t vt [NV];

  initial begin
    //            kv    kd     st    sp    cl    dc      m     t     o    mag   done
    vt[0]  = v(1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
    vt[1]  = v(1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);
    vt[2]  = v(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
    vt[3]  = v(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
    vt[4]  = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    vt[5]  = v(1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    vt[6]  = v(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    vt[7]  = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    vt[8]  = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    vt[9]  = v(1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    vt[10] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    vt[11] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    vt[12] = v(1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0);
    vt[13] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    vt[14] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    vt[15] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    vt[16] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    vt[17] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    vt[18] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    vt[19] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    vt[20] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    vt[21] = v(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    vt[22] = v(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    vt[23] = v(1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("in_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Key entry, ignored keys, start refusals, 0:02 countdown to DONE
    for (int i = 0; i < NV; i++) begin
      apply(vt[i].kv, vt[i].kd, vt[i].st, vt[i].sp, vt[i].cl, vt[i].dc);
      chk($sformatf("vec%0d", i), vt[i].m, vt[i].t, vt[i].o, vt[i].mg, vt[i].dn);
    end

    // Borrow through minutes: 1:00 -> 0:59; a key in RUN is ignored
    key(4'd1); key(4'd0); key(4'd0);
    chk("load_100", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    key(4'd7);
    nops(3);
    chk("borrow_059", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_in_run", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Borrow from tens: 0:10 -> 0:09, then stop twice (pause, then cancel)
    key(4'd1); key(4'd0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    nops(4);
    chk("borrow_009", 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stop_pause", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("stop_cancel", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // Door opened mid-second pauses; prescaler resumes from its held value
    key(4'd5);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    nops(4);
    chk("door_pre", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    nops(1);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("door_open_pause", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
    nops(2);
    chk("door_closed_hold", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("resume", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    nops(2);
    chk("resume_held_cnt", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
    nops(1);
    chk("resume_tick", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    nops(4);
    chk("resume_002", 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    nops(8);
    chk("resume_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_door_open", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    nops(1);

    // Asynchronous reset while running at 0:03
    key(4'd3);
    apply(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    nops(2);
    chk("pre_reset", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nops(1);
    chk("after_async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Time-keeping core of the microwave controller, directly upstream of the 7-segment decoder.
- Accepts keypad digits into an M:SS BCD register and counts down once per second while cooking.
- Drives the door/start/stop state machine.
- Its min, sec_tens and sec_ones outputs feed the decoder's min, sec_tens and sec_ones inputs unchanged.

Parameters:
- TICK_DIV, 100: clk cycles per 1-second tick; must be at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  keypad digit, BCD 0-9
- start  in  1  one-cycle start strobe
- stop  in  1  one-cycle stop/pause strobe
- clear  in  1  one-cycle clear strobe
- door_closed  in  1  level, 1 = door shut
- min  out  4  BCD minutes 0-9
- sec_tens  out  4  BCD tens of seconds 0-5
- sec_ones  out  4  BCD seconds 0-9
- mag_on  out  1  magnetron enable, high only in RUN
- done  out  1  high while in DONE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- All outputs are registered. Reset values: min, sec_tens and sec_ones = 0; mag_on = 0; done = 0; state = IDLE; prescaler = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority within one cycle: clear > stop > door open > start > key_valid. Only the highest-priority event acts.
- Key entry (IDLE only):
  - Shift left: min <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit. Visible the next cycle.
  - The key is ignored if key_digit > 9.
  - The key is ignored if the current sec_ones > 5, so sec_tens never leaves 0-5.
  - The old min is discarded.
  - Keys in RUN, PAUSE and DONE are ignored.
- IDLE transitions:
  - clear: zero all digits.
  - start with door_closed = 1 and time != 0:000: go to RUN, prescaler = 0.
  - start with time = 0:000 or door open: ignored.
- RUN:
  - mag_on = 1.
  - Prescaler counts 0..TICK_DIV-1. A tick occurs on the cycle it equals TICK_DIV-1, then it wraps to 0.
  - First decrement is TICK_DIV cycles after the cycle start was sampled.
  - Per tick, BCD decrement with borrow: sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min decrements on borrow.
  - The tick that produces 0:000 moves to DONE on the same edge; mag_on = 0 and done = 1 the next cycle.
  - stop or door_closed = 0: go to PAUSE. Digits hold, prescaler holds, mag_on = 0 the next cycle.
  - clear: go to IDLE, digits zeroed.
  - A tick coinciding with stop, clear or door-open is discarded: no decrement.
- PAUSE:
  - start with door_closed = 1: go to RUN, prescaler resumes from its held value.
  - stop or clear: go to IDLE, digits zeroed.
  - Door state changes alone: no effect.
- DONE:
  - Digits are 0:000, done = 1.
  - clear, stop, or door_closed = 0: go to IDLE, done = 0 the next cycle.
  - start: ignored.
- Reset mid-operation: immediate return to reset values regardless of state; mag_on drops asynchronously.
- No output goes X. Digits are always valid BCD (min 0-9, sec_tens 0-5, sec_ones 0-9).

Decomposition:
- microwave_pkg: state enum (IDLE, RUN, PAUSE, DONE), BCD constants BCD_MAX_ONES = 9 and BCD_MAX_TENS = 5, digit width constant 4.
- One sub-module, tick_gen: parameterised TICK_DIV prescaler with enable, synchronous restart and one-cycle tick output.
- The BCD decrement and state machine stay in microwave_timer.

Test Plan (TICK_DIV = 4):
- Reset, then keys 1,3,0 -> min=1, sec_tens=3, sec_ones=0. Key 12 and key 5 after sec_ones=7 are both ignored.
- Load 0:02, door closed, start -> mag_on=1 the next cycle; 0:01 after 4 cycles; 0:00 with done=1, mag_on=0 after 8 cycles.
- Load 1:00, run one tick -> 0:59. Load 0:10, one tick -> 0:09. Borrow chain is correct.
- Load 0:05, start, open the door at cycle 6 -> PAUSE, mag_on=0, digits 0:04 held. Close the door: no change. start -> resumes and reaches done.
- start with 0:000, or with door open -> stays IDLE, mag_on=0. clear and start in the same cycle -> IDLE, digits 0.
- Assert rst_n low mid-RUN at 0:03 -> all outputs 0 immediately, including mag_on, before the next clk edge.
